// File: rtl/sync_event_detect.sv
// Per-bit debouncer for already-synchronized level inputs: a change is accepted only
// after STABLE_CYCLES consecutive differing samples, producing edge pulses and sticky flags.
module sync_event_detect #(
    parameter int unsigned          WIDTH         = 4,
    parameter int unsigned          STABLE_CYCLES = 4,
    parameter logic [WIDTH-1:0]     INIT_LEVEL    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sync_in,
    input  logic [WIDTH-1:0] irq_en,
    input  logic [WIDTH-1:0] irq_clear,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] irq_status,
    output logic             irq
);

    localparam int unsigned   CW         = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(STABLE_CYCLES - 1);

    logic [CW-1:0]    count_q [WIDTH];
    logic [CW-1:0]    count_d [WIDTH];
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] accept;

    always_comb begin
        level_d = level_q;
        accept  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_d[i] = '0;
            // The sample that would reach STABLE_CYCLES is the accepting one, so the
            // counter never holds more than STABLE_CYCLES-1 and cannot wrap.
            if (sync_in[i] != level_q[i]) begin
                if (count_q[i] < LAST_COUNT) begin
                    count_d[i] = count_q[i] + CW'(1);
                end else begin
                    accept[i]  = 1'b1;
                    level_d[i] = sync_in[i];
                end
            end
        end
        rise_d   = accept & sync_in;
        fall_d   = accept & ~sync_in;
        status_d = rise_d | fall_d | (status_q & ~irq_clear);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q  <= INIT_LEVEL;
            rise_q   <= '0;
            fall_q   <= '0;
            status_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            status_q <= status_d;
            for (int i = 0; i < WIDTH; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign irq_status = status_q;
    assign irq        = |(status_q & irq_en);

endmodule

// File: tb/tb_sync_event_detect.sv
// Directed bench for sync_event_detect: a STABLE_CYCLES=4 instance for debounce, irq and
// reset behaviour, plus a STABLE_CYCLES=1 instance for the follow-every-toggle case.
module tb_sync_event_detect;

    logic       clk;
    logic       rst;
    logic [3:0] sync_in;
    logic [3:0] irq_en;
    logic [3:0] irq_clear;
    logic [3:0] level_out, rise_pulse, fall_pulse, irq_status;
    logic       irq;

    logic [3:0] sync_in_b;
    logic [3:0] level_b, rise_b, fall_b, status_b;
    logic       irq_b;

    int checks;
    int errors;

    sync_event_detect #(
        .WIDTH(4), .STABLE_CYCLES(4), .INIT_LEVEL(4'b0000)
    ) dut (
        .clk(clk), .rst(rst), .sync_in(sync_in), .irq_en(irq_en), .irq_clear(irq_clear),
        .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .irq_status(irq_status), .irq(irq)
    );

    sync_event_detect #(
        .WIDTH(4), .STABLE_CYCLES(1), .INIT_LEVEL(4'b0000)
    ) dut_fast (
        .clk(clk), .rst(rst), .sync_in(sync_in_b), .irq_en(irq_en), .irq_clear(irq_clear),
        .level_out(level_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
        .irq_status(status_b), .irq(irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] sin, input logic [3:0] en, input logic [3:0] clr);
        sync_in   = sin;
        irq_en    = en;
        irq_clear = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] lvl, input logic [3:0] rise,
                            input logic [3:0] fall, input logic [3:0] stat, input logic exp_irq);
        checkOutput({tag, "_level"},  level_out,  lvl);
        checkOutput({tag, "_rise"},   rise_pulse, rise);
        checkOutput({tag, "_fall"},   fall_pulse, fall);
        checkOutput({tag, "_status"}, irq_status, stat);
        checkOutput({tag, "_irq"},    irq,        exp_irq);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        sync_in_b = 4'b0000;
        applyStimulus(4'b0000, 4'b0001, 4'b0000);
        #1;
        checkAll("reset_async", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick();
        tick();
        checkAll("reset_clocked", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Single rising change on bit 0, accepted on the 4th sampling edge.
        rst = 1'b0;
        applyStimulus(4'b0001, 4'b0001, 4'b0000);
        tick();
        tick();
        tick();
        checkAll("rise0_edge3", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick();
        checkAll("rise0_edge4", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1);
        tick();
        checkAll("rise0_edge5", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        applyStimulus(4'b0001, 4'b0000, 4'b0000);
        #1;
        checkAll("irq_masked", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0);
        applyStimulus(4'b0001, 4'b0001, 4'b0001);
        tick();
        checkAll("clear0", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Short glitch on bit 1, then a full-length run.
        applyStimulus(4'b0011, 4'b0001, 4'b0000);
        for (int k = 0; k < 3; k++) tick();
        checkAll("glitch1_run", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b0001, 4'b0001, 4'b0000);
        tick();
        checkAll("glitch1_end", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(4'b0011, 4'b0001, 4'b0000);
        for (int k = 0; k < 3; k++) tick();
        checkAll("rise1_edge3", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick();
        checkAll("rise1_edge4", 4'b0011, 4'b0010, 4'b0000, 4'b0010, 1'b0);

        // Bit 2 rises, then falls with a clear landing on the same edge: set wins.
        applyStimulus(4'b0111, 4'b0001, 4'b0000);
        for (int k = 0; k < 4; k++) tick();
        checkAll("rise2", 4'b0111, 4'b0100, 4'b0000, 4'b0110, 1'b0);
        applyStimulus(4'b0011, 4'b0001, 4'b0000);
        for (int k = 0; k < 3; k++) tick();
        applyStimulus(4'b0011, 4'b0001, 4'b0100);
        tick();
        checkAll("fall2_set_wins", 4'b0011, 4'b0000, 4'b0100, 4'b0110, 1'b0);
        applyStimulus(4'b0011, 4'b0001, 4'b0000);
        tick();
        applyStimulus(4'b0011, 4'b0001, 4'b0100);
        tick();
        checkAll("clear2", 4'b0011, 4'b0000, 4'b0000, 4'b0010, 1'b0);
        applyStimulus(4'b0011, 4'b0001, 4'b0010);
        tick();
        applyStimulus(4'b0011, 4'b0001, 4'b1000);
        tick();
        checkAll("clear_idle_bit", 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Simultaneous rise on bit 3 and fall on bit 1, then irq masking.
        applyStimulus(4'b1001, 4'b0101, 4'b0000);
        for (int k = 0; k < 4; k++) tick();
        checkAll("simul_events", 4'b1001, 4'b1000, 4'b0010, 4'b1010, 1'b0);
        applyStimulus(4'b1001, 4'b0010, 4'b0000);
        #1;
        checkOutput("irq_comb", irq, 1'b1);

        // Reset in the middle of a partial count on bit 3.
        applyStimulus(4'b0001, 4'b0010, 4'b0000);
        tick();
        tick();
        #3;
        rst     = 1'b1;
        sync_in = 4'b1000;
        #1;
        checkAll("reset_midcount", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick();
        rst = 1'b0;
        applyStimulus(4'b1000, 4'b1111, 4'b0000);
        for (int k = 0; k < 3; k++) tick();
        checkAll("post_reset_edge3", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick();
        checkAll("post_reset_edge4", 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b1);

        // Single-sample acceptance: every toggle is followed one edge later.
        for (int k = 0; k < 6; k++) begin
            logic v;
            v         = (k % 2 == 0);
            sync_in_b = {3'b000, v};
            tick();
            checkOutput("fast_level", level_b, {3'b000, v});
            checkOutput("fast_rise",  rise_b,  {3'b000, v});
            checkOutput("fast_fall",  fall_b,  {3'b000, ~v});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_event_detect.md
SYNC_EVENT_DETECT -- requirements
Module: sync_event_detect

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of independent synchronized input bits (range 1..32).
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive-sample count needed to accept a level change (range 1..255).
REQ-003 The block SHALL have parameter INIT_LEVEL, default 0 (WIDTH bits), giving the reset value of the accepted level per bit.
REQ-004 clk  input  1  single clock; all state SHALL be on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 sync_in  input  WIDTH  level inputs, already synchronized into the clk domain by the upstream multi-flop synchronizer.
REQ-007 irq_en  input  WIDTH  per-bit interrupt enable.
REQ-008 irq_clear  input  WIDTH  per-bit write-1-to-clear strobe for irq_status; 1-cycle pulses.
REQ-009 level_out  output  WIDTH  debounced accepted level, registered.
REQ-010 rise_pulse  output  WIDTH  1-cycle pulse on an accepted 0->1 change, registered.
REQ-011 fall_pulse  output  WIDTH  1-cycle pulse on an accepted 1->0 change, registered.
REQ-012 irq_status  output  WIDTH  sticky per-bit event flag, registered.
REQ-013 irq  output  1  OR-reduction of (irq_status AND irq_en); combinational from registers only.

Function
REQ-014 Each bit SHALL own a stability counter, width clog2(STABLE_CYCLES+1), saturating and never wrapping.
REQ-015 On each edge where sync_in[i] equals level_out[i], counter[i] SHALL clear to 0.
REQ-016 On each edge where sync_in[i] differs from level_out[i] and counter[i]+1 < STABLE_CYCLES, counter[i] SHALL increment.
REQ-017 On the edge where sync_in[i] differs and counter[i]+1 = STABLE_CYCLES, level_out[i] SHALL load sync_in[i] and counter[i] SHALL clear to 0.
REQ-018 Latency: a change in sync_in[i] held stable SHALL appear on level_out[i] exactly STABLE_CYCLES edges after it is first sampled.
REQ-019 A differing run shorter than STABLE_CYCLES SHALL leave level_out, the pulses and irq_status unchanged, and the counter SHALL restart from 0 on the next differing run.
REQ-020 rise_pulse[i] SHALL be 1 for exactly the one cycle following the edge on which level_out[i] goes 0->1; fall_pulse[i] likewise for 1->0; the two SHALL never be high together for the same bit.
REQ-021 irq_status[i] SHALL set on the same edge that asserts rise_pulse[i] or fall_pulse[i].
REQ-022 irq_status[i] SHALL clear on an edge with irq_clear[i]=1 and no simultaneous set event; set SHALL win over clear on the same edge.
REQ-023 irq_clear on a bit with irq_status=0 SHALL have no effect; irq_en SHALL mask only irq, never irq_status.
REQ-024 Bits SHALL be fully independent; simultaneous events on multiple bits SHALL all be captured.
REQ-025 With STABLE_CYCLES=1, level_out SHALL follow sync_in with one edge of latency and every toggle SHALL generate a pulse.

Reset
REQ-026 While rst=1: level_out=INIT_LEVEL, counters=0, rise_pulse=0, fall_pulse=0, irq_status=0, irq=0, independent of clk.
REQ-027 Reset asserted mid-count SHALL discard partial counts; after release, a differing input SHALL need a full STABLE_CYCLES samples.
REQ-028 No pulse or irq_status set SHALL be generated by reset release itself, even if sync_in differs from INIT_LEVEL.

Verification (WIDTH=4, STABLE_CYCLES=4, INIT_LEVEL=0 unless stated)
REQ-029 Release rst, drive sync_in=4'b0001 at edge 0 and hold -> level_out=4'b0001 after edge 4, rise_pulse=4'b0001 for one cycle, irq_status[0]=1; irq=1 only if irq_en[0]=1.
REQ-030 From level 0, sync_in[1]=1 for 3 cycles then 0 -> level_out, pulses and irq_status stay 0; a following 4-cycle high run -> rise on bit 1 at its 4th sample.
REQ-031 irq_status[2]=1, then irq_clear[2]=1 on the same edge as a new fall event on bit 2 -> irq_status[2] stays 1; a later lone irq_clear[2] -> 0.
REQ-032 irq_status=4'b1010, irq_en=4'b0101 -> irq=0; irq_en=4'b0010 -> irq=1 combinationally.
REQ-033 sync_in[3] differing for 2 cycles, assert rst asynchronously between edges -> outputs and counters 0 immediately; after release, bit 3 changes only after 4 more edges.
REQ-034 STABLE_CYCLES=1, toggle sync_in[0] every cycle -> level_out[0] follows with 1-edge latency, alternating rise/fall pulses every cycle.
